// File: rtl/pc_unit.sv
// Program-counter unit: registered PC with four next-PC sources, stall, sticky misalign flag.
// Optional return-address stack compiled in when PC_RAS_EN is defined.
module pc_unit #(
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int unsigned      RAS_DEPTH    = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stall_i,
   input  logic [1:0]       PCsrc_i,
   input  logic [WIDTH-1:0] ImmOp_i,
   input  logic [WIDTH-1:0] Rs1_i,
   input  logic [WIDTH-1:0] TrapVec_i,
   input  logic             link_i,
   input  logic             ret_i,
   output logic [WIDTH-1:0] PC_o,
   output logic [WIDTH-1:0] PC_Plus4_o,
   output logic             misalign_o,
   output logic [WIDTH-1:0] ras_top_o,
   output logic             ras_valid_o
);

   logic [WIDTH-1:0] pc_q;
   logic             misalign_q, misalign_d;
   logic [WIDTH-1:0] inc, br, jr, tv, target;
   logic             target_misaligned, is_trap, accept;

   assign inc = pc_q + WIDTH'(4);
   assign br  = pc_q + ImmOp_i;
   assign jr  = (Rs1_i + ImmOp_i) & ~WIDTH'(1);
   assign tv  = TrapVec_i & ~WIDTH'(3);

   always_comb begin
      target = inc;
      unique case (PCsrc_i)
         2'b00: target = inc;
         2'b01: target = br;
         2'b10: target = jr;
         2'b11: target = tv;
      endcase
   end

   assign target_misaligned = (target[1:0] != 2'b00);
   assign is_trap           = (PCsrc_i == 2'b11);

   // A trap is the only way out of the sticky misaligned state.
   assign accept = !stall_i && (is_trap || (!misalign_q && !target_misaligned));

   always_comb begin
      misalign_d = misalign_q;
      if (accept && is_trap) begin
         misalign_d = 1'b0;
      end else if (!stall_i && !is_trap && target_misaligned) begin
         misalign_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q       <= RESET_VECTOR;
         misalign_q <= 1'b0;
      end else begin
         if (accept) begin
            pc_q <= target;
         end
         misalign_q <= misalign_d;
      end
   end

   assign PC_o       = pc_q;
   assign PC_Plus4_o = inc;
   assign misalign_o = misalign_q;

`ifdef PC_RAS_EN
   localparam int unsigned PtrW = $clog2(RAS_DEPTH);
   localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

   logic [WIDTH-1:0] ras_q [RAS_DEPTH];
   logic [PtrW-1:0]  ptr_q, ptr_d, wr_ptr;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             do_push, do_pop, wr_en;

   assign do_push = accept && link_i;
   assign do_pop  = accept && ret_i && (cnt_q != '0);

   // ptr_q always addresses the top; a push past capacity overwrites the oldest slot.
   always_comb begin
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      wr_en  = 1'b0;
      wr_ptr = ptr_q;
      if (do_push && do_pop) begin
         wr_en  = 1'b1;
         wr_ptr = ptr_q;
      end else if (do_push) begin
         ptr_d  = ptr_q + 1'b1;
         wr_ptr = ptr_d;
         wr_en  = 1'b1;
         if (cnt_q != CntW'(RAS_DEPTH)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (do_pop) begin
         ptr_d = ptr_q - 1'b1;
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && wr_en) begin
         ras_q[wr_ptr] <= inc;
      end
   end

   assign ras_valid_o = (cnt_q != '0);
   assign ras_top_o   = ras_valid_o ? ras_q[ptr_q] : '0;
`else
   logic unused_ras;
   assign unused_ras  = link_i ^ ret_i;
   assign ras_valid_o = 1'b0;
   assign ras_top_o   = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; RAS expectations collapse to zero
// when PC_RAS_EN is not defined.
module tb_pc_unit;

   localparam int unsigned WIDTH = 32;
   localparam logic [31:0] RV    = 32'h100;
`ifdef PC_RAS_EN
   localparam bit RasOn = 1'b1;
`else
   localparam bit RasOn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, stall, link, ret;
   logic [1:0]  src;
   logic [31:0] imm, rs1, tvec;
   logic [31:0] pc, pc4, ras_top;
   logic        mis, ras_valid;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pc_unit #(
      .WIDTH       (WIDTH),
      .RESET_VECTOR(RV),
      .RAS_DEPTH   (4)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .stall_i    (stall),
      .PCsrc_i    (src),
      .ImmOp_i    (imm),
      .Rs1_i      (rs1),
      .TrapVec_i  (tvec),
      .link_i     (link),
      .ret_i      (ret),
      .PC_o       (pc),
      .PC_Plus4_o (pc4),
      .misalign_o (mis),
      .ras_top_o  (ras_top),
      .ras_valid_o(ras_valid)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample 1 ns after the edge.
   task automatic step(input logic [1:0] s, input logic [31:0] i, input logic [31:0] r,
                       input logic [31:0] t, input logic lk, input logic rt, input logic st);
      src = s; imm = i; rs1 = r; tvec = t; link = lk; ret = rt; stall = st;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rtop(input logic [31:0] v);
      return RasOn ? v : 32'h0;
   endfunction

   function automatic logic [31:0] rval(input logic v);
      return RasOn ? {31'b0, v} : 32'h0;
   endfunction

   initial begin
      rst = 1'b1; stall = 1'b0; link = 1'b0; ret = 1'b0;
      src = 2'b00; imm = '0; rs1 = '0; tvec = '0;

      // Reset state
      step(2'b00, 0, 0, 0, 0, 0, 0);
      check_eq("rst_pc", pc, 32'h100);
      check_eq("rst_pc4", pc4, 32'h104);
      check_eq("rst_mis", {31'b0, mis}, 0);
      check_eq("rst_rasv", {31'b0, ras_valid}, 0);
      check_eq("rst_rast", ras_top, 0);
      rst = 1'b0;

      // Sequential
      for (int k = 1; k <= 3; k++) begin
         step(2'b00, 0, 0, 0, 0, 0, 0);
         check_eq("seq_pc", pc, 32'h100 + 32'(4 * k));
         check_eq("seq_pc4", pc4, 32'h104 + 32'(4 * k));
      end

      // Branch to 0x200, negative branch, JALR with bit0 cleared, stall
      step(2'b01, 32'hF4, 0, 0, 0, 0, 0);
      check_eq("br_fwd", pc, 32'h200);
      step(2'b01, 32'hFFFF_FFF0, 0, 0, 0, 0, 0);
      check_eq("br_back", pc, 32'h1F0);
      step(2'b10, 32'h0, 32'h301, 0, 0, 0, 0);
      check_eq("jalr", pc, 32'h300);
      step(2'b01, 32'h40, 0, 0, 0, 0, 1);
      check_eq("stall1", pc, 32'h300);
      step(2'b01, 32'h40, 0, 0, 0, 0, 1);
      check_eq("stall2", pc, 32'h300);

      // Misaligned branch sets sticky flag
      step(2'b01, 32'h2, 0, 0, 0, 0, 0);
      check_eq("mis_pc", pc, 32'h300);
      check_eq("mis_flag", {31'b0, mis}, 1);
      step(2'b00, 0, 0, 0, 0, 0, 0);
      check_eq("mis_hold_pc", pc, 32'h300);
      check_eq("mis_hold_flag", {31'b0, mis}, 1);
      step(2'b11, 0, 0, 32'h8003, 0, 0, 1);
      check_eq("mis_stall_trap_pc", pc, 32'h300);
      check_eq("mis_stall_trap_flag", {31'b0, mis}, 1);
      step(2'b11, 0, 0, 32'h8003, 0, 0, 0);
      check_eq("trap_pc", pc, 32'h8000);
      check_eq("trap_flag", {31'b0, mis}, 0);

      // Misaligned JALR target (bit 1 set survives the bit-0 clear)
      step(2'b10, 32'h1, 32'h2, 0, 0, 0, 0);
      check_eq("jr_mis_pc", pc, 32'h8000);
      check_eq("jr_mis_flag", {31'b0, mis}, 1);
      step(2'b11, 0, 0, 32'h0, 0, 0, 0);
      check_eq("trap0_pc", pc, 32'h0);
      check_eq("trap0_flag", {31'b0, mis}, 0);

      // Wrap-around
      step(2'b01, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
      check_eq("wrap_pre", pc, 32'hFFFF_FFFC);
      check_eq("wrap_pc4", pc4, 32'h0);
      step(2'b00, 0, 0, 0, 0, 0, 0);
      check_eq("wrap_pc", pc, 32'h0);
      check_eq("wrap_flag", {31'b0, mis}, 0);

      // RAS: 5 pushes from 0x10..0x50, depth 4
      step(2'b01, 32'h10, 0, 0, 0, 0, 0);
      check_eq("ras_start_pc", pc, 32'h10);
      for (int k = 1; k <= 5; k++) begin
         step(2'b01, 32'h10, 0, 0, 1, 0, 0);
         check_eq("push_top", ras_top, rtop(32'(16 * k + 4)));
         check_eq("push_valid", rval(ras_valid), rval(1'b1));
      end
      check_eq("push_pc", pc, 32'h60);

      // Rejected (misaligned) update must not push
      step(2'b01, 32'h2, 0, 0, 1, 0, 0);
      check_eq("mis_nopush", ras_top, rtop(32'h54));
      step(2'b11, 0, 0, 32'h80, 0, 0, 0);
      check_eq("trap80_pc", pc, 32'h80);

      // Pops
      step(2'b00, 0, 0, 0, 0, 1, 0);
      check_eq("pop1", ras_top, rtop(32'h44));
      step(2'b00, 0, 0, 0, 0, 1, 0);
      check_eq("pop2", ras_top, rtop(32'h34));
      step(2'b00, 0, 0, 0, 0, 1, 0);
      check_eq("pop3", ras_top, rtop(32'h24));
      step(2'b00, 0, 0, 0, 0, 1, 0);
      check_eq("pop4_valid", {31'b0, ras_valid}, 0);
      check_eq("pop4_top", ras_top, 0);
      step(2'b00, 0, 0, 0, 0, 1, 0);
      check_eq("pop5_valid", {31'b0, ras_valid}, 0);
      check_eq("pop5_top", ras_top, 0);
      check_eq("pop5_pc", pc, 32'h94);

      // Push, then simultaneous link/ret replaces the top
      step(2'b00, 0, 0, 0, 1, 0, 0);
      check_eq("one_push", ras_top, rtop(32'h98));
      step(2'b00, 0, 0, 0, 1, 1, 0);
      check_eq("swap_top", ras_top, rtop(32'h9C));
      check_eq("swap_valid", rval(ras_valid), rval(1'b1));
      step(2'b00, 0, 0, 0, 0, 1, 1);
      check_eq("stall_ras_top", ras_top, rtop(32'h9C));
      check_eq("stall_ras_pc", pc, 32'h9C);
      step(2'b00, 0, 0, 0, 0, 1, 0);
      check_eq("swap_count", {31'b0, ras_valid}, 0);

      // Two entries plus flag set, then reset while stalled
      step(2'b00, 0, 0, 0, 1, 0, 0);
      step(2'b00, 0, 0, 0, 1, 0, 0);
      check_eq("two_top", ras_top, rtop(32'hA8));
      step(2'b10, 32'h0, 32'h3, 0, 0, 0, 0);
      check_eq("pre_rst_flag", {31'b0, mis}, 1);
      rst = 1'b1;
      step(2'b01, 32'h40, 0, 0, 1, 1, 1);
      rst = 1'b0;
      check_eq("rst2_pc", pc, 32'h100);
      check_eq("rst2_pc4", pc4, 32'h104);
      check_eq("rst2_rasv", {31'b0, ras_valid}, 0);
      check_eq("rst2_rast", ras_top, 0);
      check_eq("rst2_mis", {31'b0, mis}, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Registered program-counter unit for the single-cycle/pipelined RISC-V core. It holds the architectural PC and selects the next PC from four sources: sequential, branch, JALR and trap vector. It supports fetch stalls and detects misaligned targets. An optional return-address stack (RAS) can be compiled in. It sits at the head of the fetch path and drives instruction-memory address and PC+4 to the link-register writeback.

## Interface
Parameters:
- WIDTH, 32, datapath/address width in bits (≥ 8)
- RESET_VECTOR, 0, PC value loaded on reset; bits [1:0] must be 0
- RAS_DEPTH, 4, RAS entries (power of two, ≥ 2); unused unless PC_RAS_EN is defined

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- stall_i  in  1  hold all state this cycle
- PCsrc_i  in  2  next-PC select: 00 PC+4, 01 PC+ImmOp, 10 (Rs1+ImmOp) with bit 0 cleared, 11 TrapVec
- ImmOp_i  in  WIDTH  sign-extended immediate
- Rs1_i  in  WIDTH  JALR base register value
- TrapVec_i  in  WIDTH  trap handler address; bits [1:0] are ignored and forced to 00
- link_i  in  1  current instruction is a call; push PC+4 to the RAS
- ret_i  in  1  current instruction is a return; pop the RAS
- PC_o  out  WIDTH  current PC (registered)
- PC_Plus4_o  out  WIDTH  PC_o + 4 (combinational from PC_o)
- misalign_o  out  1  sticky misaligned-target flag (registered)
- ras_top_o  out  WIDTH  RAS top entry; 0 when empty
- ras_valid_o  out  1  RAS non-empty

## Operation
- Target computation, all modulo 2^WIDTH (carry discarded):
  - inc = PC_o + 4
  - br = PC_o + ImmOp_i
  - jr = (Rs1_i + ImmOp_i) & ~1
  - tv = TrapVec_i & ~3
- Misaligned: the selected target has bits [1:0] ≠ 00. This applies only to PCsrc 01 and 10; inc and tv are always aligned.
- Update accepted = !stall_i && !misalign_o && selected target aligned. A trap select (11) is always accepted when !stall_i, even with misalign_o set.
- Accepted update: PC_o ← selected target.
- Misaligned, not stalled: PC_o holds and misalign_o ← 1.
- misalign_o clears only on reset or on an accepted trap select. While it is set, selects 00/01/10 are ignored: PC_o holds.
- RAS, when compiled in:
  - Acts only on accepted updates.
  - link_i pushes the current PC_o + 4.
  - ret_i pops.
  - link_i && ret_i together: pop then push; the top is replaced and the count is unchanged.
  - Overflow: a push at RAS_DEPTH entries overwrites the oldest entry (circular pointer); the count saturates at RAS_DEPTH.
  - Underflow: a pop when empty is ignored; the count stays 0.
- The RAS is a hint output only. It never steers PC_o.

## Timing
- Reset values on the cycle after rst_i is high at an edge:
  - PC_o = RESET_VECTOR
  - PC_Plus4_o = RESET_VECTOR + 4
  - misalign_o = 0
  - RAS empty: ras_valid_o = 0, ras_top_o = 0
- rst_i overrides stall_i and all other inputs. Reset asserted mid-operation discards all RAS contents.
- Next-PC latency: inputs sampled at edge N appear on PC_o after edge N.
- PC_Plus4_o, ras_top_o and ras_valid_o follow state combinationally, with no additional latency.
- stall_i high: PC_o, misalign_o, RAS pointer, RAS contents and count all hold, regardless of PCsrc_i, link_i and ret_i.
- Wrap-around: PC_o = 2^WIDTH−4 with select 00 gives PC_o = 0 next cycle, with no flag.

## Configuration
- PC_RAS_EN defined: the RAS is instantiated with RAS_DEPTH entries, behaving as in Operation.
- PC_RAS_EN undefined:
  - No RAS storage.
  - ras_top_o is tied to 0 and ras_valid_o to 0.
  - link_i and ret_i are ignored.
  - All other behaviour is identical.

## Test plan
- Reset with RESET_VECTOR=0x100, then 3 cycles of PCsrc=00 → PC_o = 0x100, 0x104, 0x108, 0x10C; PC_Plus4_o = PC_o + 4 throughout.
- At PC 0x200: PCsrc=01 with ImmOp=0xFFFFFFF0 → PC_o = 0x1F0. Then PCsrc=10 with Rs1=0x301, ImmOp=0 → PC_o = 0x300. Then stall_i high for 2 cycles with PCsrc=01 → PC_o stays 0x300.
- At PC 0x300: PCsrc=01 with ImmOp=0x2 → PC_o stays 0x300 and misalign_o=1. Then PCsrc=00 → PC_o stays 0x300. Then PCsrc=11 with TrapVec=0x8003 → PC_o = 0x8000 and misalign_o=0.
- Wrap: force PC_o to 0xFFFFFFFC via branch, then PCsrc=00 → PC_o = 0x00000000 and misalign_o=0.
- PC_RAS_EN, RAS_DEPTH=4:
  - 5 pushes from PCs 0x10, 0x20, 0x30, 0x40, 0x50 → ras_top_o = 0x54.
  - 4 pops → tops 0x44, 0x34, 0x24, then ras_valid_o=0.
  - A fifth pop stays empty with ras_top_o=0.
  - Simultaneous link_i/ret_i replaces the top without changing the count.
- rst_i asserted while stall_i=1 and the RAS holds 2 entries → next cycle PC_o = RESET_VECTOR, ras_valid_o=0, misalign_o=0.
